// File: rtl/tile_lane.sv
// tile_lane: one Piano Tiles lane; a circular FIFO of falling tiles scored by hit/miss/escape.
// Defining TILE_LANE_LIVES_EN grants three lives per game and adds the lives output.
module tile_lane #(
    parameter int DEPTH     = 8,
    parameter int LANE_X    = 80,
    parameter int TILE_W    = 150,
    parameter int TILE_H    = 75,
    parameter int Y_MAX     = 479,
    parameter int HIT_Y_MIN = 380,
    parameter int SCORE_W   = 16
) (
    input  logic                       frame_clk,
    input  logic                       Reset,
    input  logic                       start,
    input  logic                       spawn,
    input  logic                       key,
    input  logic [3:0]                 speed,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic                       rd_valid,
    output logic [9:0]                 rd_y,
    output logic [9:0]                 tile_x,
    output logic [9:0]                 tile_w,
    output logic [9:0]                 tile_h,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       hit,
    output logic                       miss,
    output logic                       overflow,
    output logic [SCORE_W-1:0]         score,
`ifdef TILE_LANE_LIVES_EN
    output logic [1:0]                 lives,
`endif
    output logic [1:0]                 state
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, OVER = 2'b10} state_t;

    state_t        st_q, st_d;
    logic [9:0]    ys [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          key_q;
    logic [11:0]   bottom;
    logic [PW:0]   left;
    logic          key_edge, live, in_zone, do_hit, do_miss, escape, pop, go_over, enter, push, ovf;
`ifdef TILE_LANE_LIVES_EN
    logic [1:0]    lives_q;
    assign lives = lives_q;
`endif

    always_comb begin
        key_edge = key & ~key_q;
        live     = count != '0;
        bottom   = 12'(ys[rd_ptr]) + 12'(TILE_H);
        in_zone  = live && bottom >= 12'(HIT_Y_MIN);
        do_hit   = st_q == RUN && key_edge && in_zone;
        escape   = st_q == RUN && live && !do_hit && bottom + 12'(speed) > 12'(Y_MAX);
        do_miss  = (st_q == RUN && key_edge && !in_zone) || escape;
        pop      = do_hit || escape;
        left     = count - (PW+1)'(pop);
`ifdef TILE_LANE_LIVES_EN
        go_over  = do_miss && lives_q == 2'd1;
`else
        go_over  = do_miss;
`endif
        enter    = st_q != RUN && start;
        // a frame that ends the game only retires tiles; motion and spawns freeze with it
        push     = st_q == RUN && !go_over && spawn && left < (PW+1)'(DEPTH);
        ovf      = st_q == RUN && !go_over && spawn && left == (PW+1)'(DEPTH);
        st_d     = enter ? RUN : go_over ? OVER : st_q;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            st_q     <= IDLE;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            score    <= '0;
            hit      <= 1'b0;
            miss     <= 1'b0;
            overflow <= 1'b0;
            key_q    <= 1'b0;
            ys       <= '{default: '0};
`ifdef TILE_LANE_LIVES_EN
            lives_q  <= 2'd0;
`endif
        end else begin
            st_q     <= st_d;
            key_q    <= key;
            hit      <= do_hit;
            miss     <= do_miss;
            overflow <= ovf;
            if (enter) begin
                count   <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                score   <= '0;
`ifdef TILE_LANE_LIVES_EN
                lives_q <= 2'd3;
`endif
            end else if (st_q == RUN) begin
                if (do_hit && score != '1)
                    score <= score + SCORE_W'(1);
                rd_ptr <= rd_ptr + PW'(pop);
                count  <= left + (PW+1)'(push);
                if (!go_over)
                    for (int i = 0; i < DEPTH; i++)
                        ys[i] <= ys[i] + 10'(speed);
                if (push) begin
                    ys[wr_ptr] <= '0;
                    wr_ptr     <= wr_ptr + PW'(1);
                end
`ifdef TILE_LANE_LIVES_EN
                if (do_miss)
                    lives_q <= lives_q - 2'd1;
`endif
            end
        end
    end

    assign state    = st_q;
    assign rd_valid = {1'b0, rd_idx} < count;
    assign rd_y     = rd_valid ? ys[rd_ptr + rd_idx] : '0;
    assign tile_x   = 10'(LANE_X);
    assign tile_w   = 10'(TILE_W);
    assign tile_h   = 10'(TILE_H);
endmodule

// File: doc/tile_lane.md
Name: tile_lane

Overview:
- Parametrised successor to the single-object mover: one Piano Tiles lane holding up to DEPTH falling tiles in a circular FIFO.
- Every frame_clk all live tiles advance down by a programmable speed; spawns push at the top and hits or misses pop the oldest tile.
- Tile geometry is exposed through a random-access read port for the colour mapper; hit/miss pulses and score go to the game controller.
- One instance per lane (typically 4).

Parameters:
- DEPTH, 8, tile slots in the lane FIFO (power of 2, ≥2).
- LANE_X, 80, left X of the lane (drawing only; passed through).
- TILE_W, 150, tile width in pixels (passed through).
- TILE_H, 75, tile height in pixels.
- Y_MAX, 479, bottom screen row.
- HIT_Y_MIN, 380, lowest bottom-edge row at which a key press counts as a hit.
- SCORE_W, 16, score counter width.

Ports:
- frame_clk  in  1  frame-rate clock (one tick per frame).
- Reset  in  1  asynchronous, active-high.
- start  in  1  level; leaves IDLE/OVER and begins play.
- spawn  in  1  level sampled each frame; push a new tile at Y=0.
- key  in  1  lane key level (keycode decode done upstream).
- speed  in  4  pixels per frame; 0 freezes motion.
- rd_idx  in  log2(DEPTH)  slot offset from the oldest tile.
- rd_valid  out  1  rd_idx < count.
- rd_y  out  10  top Y of the addressed tile (0 if not rd_valid).
- tile_x, tile_w, tile_h  out  10 each  constants LANE_X, TILE_W, TILE_H.
- count  out  log2(DEPTH)+1  live tiles.
- hit  out  1  one-frame pulse on a successful hit.
- miss  out  1  one-frame pulse on an escaped tile or wrong press.
- overflow  out  1  one-frame pulse when a spawn was dropped.
- score  out  SCORE_W  hits since start.
- state  out  2  00 IDLE, 01 RUN, 10 OVER.

Behaviour:
- Reset (asynchronous, any time, including mid-game): state=IDLE, count=0, rd/wr pointers=0, score=0, hit=miss=overflow=0, key history=0.
- IDLE: no motion, spawns ignored. start → RUN; count and score cleared on entry.
- RUN evaluation order within one edge, all on pre-update values:
  - Key edge: key rising edge = key & ~key_q (key_q registered every frame).
  - Key edge while count>0 and oldest.y+TILE_H ≥ HIT_Y_MIN → hit=1, score+1 (saturate at all-ones), pop oldest.
  - Key edge otherwise (empty lane or oldest above zone) → miss=1, no pop.
  - Escape: independently, the oldest tile not popped by a hit with oldest.y+TILE_H+speed > Y_MAX → miss=1, pop. Hit and escape cannot both pop the same tile.
  - Motion: every remaining tile y ← y+speed. 10-bit add; wrap impossible because tiles retire first.
  - Spawn: if spawn=1 and post-pop count<DEPTH, write y=0 at wr pointer. The new tile is not moved this frame.
  - Overflow: if spawn=1 and the lane is full after pops → overflow=1, spawn dropped.
  - Pops and pushes in the same edge net correctly in count.
- Any miss in RUN → OVER on the same edge, unless TILE_LANE_LIVES_EN is defined.
- OVER: tiles frozen and still readable; score held. start → RUN, which clears the lane and score.
- Pulse width: hit, miss and overflow are registered and asserted for exactly one frame_clk period.
- Read port is combinational: slot = rd_ptr+rd_idx mod DEPTH. Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: TILE_LANE_LIVES_EN.
- Defined: adds a 2-bit lives register, set to 3 on RUN entry. Each miss decrements it; transition to OVER only when a miss occurs with lives=1. Adds output lives [1:0], which reads 0 in IDLE and OVER.
- Undefined: first miss ends the game; no lives port.

Test Plan:
- Reset mid-RUN with 3 tiles → next read: state=00, count=0, score=0, rd_valid=0.
- start, spawn 1 frame, speed=5 → after N frames rd_y(0)=5·(N−1). With HIT_Y_MIN=380, TILE_H=75, press at frame with y=310 → hit=1, score=1, count=0.
- Tile at y=300 with speed=5, key press → miss=1, state=OVER, tile still readable at y=300.
- No key, speed=4, tile reaches y+75+4 > 479 (y=401) → miss=1 that frame, count decremented, state=OVER.
- spawn held for 9 frames with DEPTH=8 → count=8, overflow pulses on the 9th frame only. Hit and spawn in the same frame → count stays 8, no overflow.
- With TILE_LANE_LIVES_EN: 3 escaped tiles → lives 3→2→1, state=OVER on the 3rd miss; start → lives=3, score=0.
